// File: rtl/csa_mul_seq.sv
// ============================================================================
// Module   : csa_mul_seq
// Brief    : Iterative RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU),
//            radix-4 shift-add through a 3-input carry-save adder, 2 bits/cycle.
//            Optional: CSA_MUL_ZERO_BYPASS_EN skips CALC/FIX for zero operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN/2 + 1);
    localparam logic [CW-1:0] c_COUNT_INIT = CW'(XLEN/2);
    localparam logic [CW-1:0] c_COUNT_LAST = CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_count;
    logic            r_neg;
    logic [XLEN-1:0] r_result;

    // Operand conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH
    logic            w_rs1_signed;
    logic            w_rs2_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_rs1_mag;
    logic [XLEN-1:0] w_rs2_mag;
    logic            w_accept;
    logic            w_zero_op;

    assign w_rs1_signed = (op == 2'b01) || (op == 2'b10);
    assign w_rs2_signed = (op == 2'b01);
    assign w_rs1_neg    = w_rs1_signed && rs1[XLEN-1];
    assign w_rs2_neg    = w_rs2_signed && rs2[XLEN-1];
    assign w_rs1_mag    = w_rs1_neg ? (~rs1 + 1'b1) : rs1;
    assign w_rs2_mag    = w_rs2_neg ? (~rs2 + 1'b1) : rs2;
    assign w_accept     = (r_state == c_IDLE) && in_valid && !kill;
    assign w_zero_op    = (rs1 == '0) || (rs2 == '0);

    // 3-input carry-save adder, resolved to a single XLEN+2 sum
    logic [XLEN+1:0] w_csa_a;
    logic [XLEN+1:0] w_csa_b;
    logic [XLEN+1:0] w_csa_c;
    logic [XLEN+1:0] w_csa_ps;
    logic [XLEN+1:0] w_csa_pc;
    logic [XLEN+1:0] w_sum;

    assign w_csa_a  = {2'b00, r_acc};
    assign w_csa_b  = r_mplier[0] ? {2'b00, r_mcand} : '0;
    assign w_csa_c  = r_mplier[1] ? {1'b0, r_mcand, 1'b0} : '0;
    assign w_csa_ps = w_csa_a ^ w_csa_b ^ w_csa_c;
    assign w_csa_pc = (w_csa_a & w_csa_b) | (w_csa_a & w_csa_c) | (w_csa_b & w_csa_c);
    assign w_sum    = w_csa_ps + (w_csa_pc << 1);

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;

    assign w_prod     = {r_acc, r_mplier};
    assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid && !kill) begin
`ifdef CSA_MUL_ZERO_BYPASS_EN
                    w_next = w_zero_op ? c_DONE : c_CALC;
`else
                    w_next = c_CALC;
`endif
                end
            end
            c_CALC: begin
                if (kill) begin
                    w_next = c_IDLE;
                end else if (r_count == c_COUNT_LAST) begin
                    w_next = c_FIX;
                end
            end
            c_FIX: begin
                w_next = kill ? c_IDLE : c_DONE;
            end
            c_DONE: begin
                if (kill || out_ready) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            c_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= op;
                r_mcand  <= w_rs1_mag;
                r_mplier <= w_rs2_mag;
                r_acc    <= '0;
                r_count  <= c_COUNT_INIT;
                r_neg    <= w_rs1_neg ^ w_rs2_neg;
`ifdef CSA_MUL_ZERO_BYPASS_EN
                if (w_zero_op) begin
                    r_result <= '0;
                end
`endif
            end
            if (r_state == c_CALC) begin
                r_acc    <= w_sum[XLEN+1:2];
                r_mplier <= {w_sum[1:0], r_mplier[XLEN-1:2]};
                r_count  <= r_count - 1'b1;
            end
            if ((r_state == c_FIX) && !kill) begin
                r_result <= (r_op == 2'b00) ? w_prod_fix[XLEN-1:0]
                                            : w_prod_fix[2*XLEN-1:XLEN];
            end
        end
    end

    assign result = r_result;

`ifndef CSA_MUL_ZERO_BYPASS_EN
    logic w_unused;
    assign w_unused = w_zero_op;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_mul_seq.sv
// ============================================================================
// Module   : tb_csa_mul_seq
// Brief    : Self-checking bench for csa_mul_seq against a 64-bit arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_mul_seq;

    localparam int XLEN = 32;
`ifdef CSA_MUL_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = XLEN/2 + 2;
`endif
    localparam int LAT = XLEN/2 + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int total = 0;
    int bad   = 0;

    csa_mul_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] f_op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (f_op == 2'b01 || f_op == 2'b10) ? $signed({{32{a[31]}}, a})
                                              : $signed({32'b0, a});
        sb = (f_op == 2'b01) ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        p  = sa * sb;
        return (f_op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request, measure latency from the accept cycle, check the
    // response, hold it under backpressure for bp cycles, then drain.
    task automatic run_op(input string tag, input logic [1:0] f_op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int bp);
        logic [31:0] exp;
        int lat;
        exp = ref_mul(f_op, a, b);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = f_op;
        rs1      = a;
        rs2      = b;
        tick();
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk({tag, "_bp_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_bp_result"}, result, exp);
            chk({tag, "_bp_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_drain_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        rs1       = '0;
        rs2       = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);

        // Directed cases
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, LAT, 0);
        chk("mul_7x6_const", result, 32'h0000002A);
        run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, LAT, 0);
        chk("mulh_min_const", result, 32'h40000000);
        run_op("mulh_m1x2", 2'b01, 32'hFFFFFFFF, 32'h00000002, LAT, 0);
        run_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, 0);
        run_op("mulhsu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, 0);
        run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, 5);
        run_op("mulhsu_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, LAT, 0);

        // kill while idle blocks acceptance
        in_valid = 1'b1;
        kill     = 1'b1;
        op       = 2'b00;
        rs1      = 32'd9;
        rs2      = 32'd9;
        tick();
        in_valid = 1'b0;
        kill     = 1'b0;
        chk("kill_idle_busy", {31'b0, busy}, 32'd0);

        // kill in CALC cycle 8, then a fresh request
        in_valid = 1'b1;
        op       = 2'b01;
        rs1      = 32'h12345678;
        rs2      = 32'h9ABCDEF0;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("kill_calc_busy_before", {31'b0, busy}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_calc_busy", {31'b0, busy}, 32'd0);
        chk("kill_calc_valid", {31'b0, out_valid}, 32'd0);
        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, LAT, 0);
        chk("mul_3x5_const", result, 32'h0000000F);

        // reset mid-CALC
        in_valid = 1'b1;
        op       = 2'b11;
        rs1      = 32'hDEADBEEF;
        rs2      = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_result", result, 32'd0);

        // Zero operands
        run_op("mul_zero", 2'b00, 32'd0, 32'h12345678, ZLAT, 0);
        run_op("mulh_zero", 2'b01, 32'hF0000001, 32'd0, ZLAT, 2);

        // Randomised operands and backpressure
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            logic [1:0]  f;
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (n % 6 == 1) a = 32'h80000000;
            if (n % 6 == 3) b = 32'hFFFFFFFF;
            run_op("rand", f, a, b, LAT, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
